// File: rtl/axis_buf_if.sv
// AXI-Stream bundle used by axis_buf: payload, tlast and the valid/ready handshake.
interface axis_buf_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 256
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_buf.sv
// AXI-Stream skid/FIFO buffer with registered master outputs and registered s_axis tready.
// Define AXIS_BUF_LEVEL_EN to add the level and almost_full outputs.
module axis_buf #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int DEPTH            = 4,
  parameter int AFULL_LEVEL      = DEPTH - 1
) (
  input  logic       axis_aclk,
  input  logic       axis_reset,
  axis_buf_if.slave  s_axis,
  axis_buf_if.master m_axis
`ifdef AXIS_BUF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
`endif
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]  data;
    logic [KEEP_W-1:0]           keep;
    logic [AXIS_TUSER_WIDTH-1:0] user;
    logic                        last;
  } beat_t;

  // Head beat lives in the output register; only the beats behind it sit in mem,
  // so mem never holds more than DEPTH-1 entries and rd_ptr==wr_ptr means empty.
  beat_t             mem [DEPTH];
  beat_t             in_beat;
  beat_t             out_beat, out_beat_nxt;
  logic              out_valid, out_valid_nxt;
  logic              in_ready;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              push, pop, mem_wr, mem_empty;
`ifdef AXIS_BUF_LEVEL_EN
  logic              afull_q;
`endif

  assign in_beat   = '{data: s_axis.tdata, keep: s_axis.tkeep, user: s_axis.tuser, last: s_axis.tlast};
  assign push      = s_axis.tvalid & in_ready;
  assign pop       = out_valid & m_axis.tready;
  assign mem_empty = (rd_ptr == wr_ptr);

  always_comb begin
    rd_ptr_nxt    = rd_ptr;
    wr_ptr_nxt    = wr_ptr;
    out_valid_nxt = out_valid;
    out_beat_nxt  = out_beat;
    mem_wr        = 1'b0;
    if (!out_valid || pop) begin
      if (!mem_empty) begin
        out_beat_nxt  = mem[rd_ptr];
        rd_ptr_nxt    = rd_ptr + 1'b1;
        out_valid_nxt = 1'b1;
        mem_wr        = push;
      end else if (push) begin
        // bypass straight into the output register for one-cycle latency
        out_beat_nxt  = in_beat;
        out_valid_nxt = 1'b1;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else begin
      mem_wr = push;
    end
    if (mem_wr) wr_ptr_nxt = wr_ptr + 1'b1;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_beat  <= '0;
      in_ready  <= 1'b0;
`ifdef AXIS_BUF_LEVEL_EN
      afull_q   <= 1'b0;
`endif
    end else begin
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      count     <= count_nxt;
      out_valid <= out_valid_nxt;
      out_beat  <= out_beat_nxt;
      in_ready  <= (count_nxt < CNT_W'(DEPTH));
`ifdef AXIS_BUF_LEVEL_EN
      afull_q   <= (32'(count_nxt) >= AFULL_LEVEL);
`endif
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_reset && mem_wr) mem[wr_ptr] <= in_beat;
  end

  assign s_axis.tready = in_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tkeep  = out_beat.keep;
  assign m_axis.tuser  = out_beat.user;
  assign m_axis.tlast  = out_beat.last;

`ifdef AXIS_BUF_LEVEL_EN
  assign level       = count;
  assign almost_full = afull_q;
`endif

endmodule

// File: doc/axis_buf.md
AXIS_BUF -- requirements
Module: axis_buf

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 512, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter AXIS_TUSER_WIDTH, default 256, tuser width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, beat capacity (power of 2, 2..64); other values are illegal.
REQ-004 SHALL have parameter AFULL_LEVEL, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port axis_aclk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port axis_reset  input  1  synchronous active-high reset.
REQ-008 SHALL have ports s_axis_tdata/tkeep/tuser/tvalid/tlast  input  AXIS_DATA_WIDTH / AXIS_DATA_WIDTH/8 / AXIS_TUSER_WIDTH / 1 / 1  slave stream.
REQ-009 SHALL have port s_axis_tready  output  1  slave ready; driven directly by a flop.
REQ-010 SHALL have ports m_axis_tdata/tkeep/tuser/tvalid/tlast  output  same widths  master stream; all driven directly by flops.
REQ-011 SHALL have port m_axis_tready  input  1  master ready.
REQ-012 SHALL have port level  output  clog2(DEPTH+1)  current occupancy (AXIS_BUF_LEVEL_EN only).
REQ-013 SHALL have port almost_full  output  1  level >= AFULL_LEVEL, registered (AXIS_BUF_LEVEL_EN only).

Function
REQ-014 Push: a beat is accepted on an edge where s_axis_tvalid && s_axis_tready.
REQ-015 Pop: a beat leaves on an edge where m_axis_tvalid && m_axis_tready.
REQ-016 Ordering: beats leave in acceptance order; tdata, tkeep, tuser and tlast pass unmodified as one unit.
REQ-017 Latency: a beat pushed into an empty buffer at edge N is presented with m_axis_tvalid=1 after edge N (one cycle).
REQ-018 Throughput: sustained one beat per cycle when both sides stay ready, for every DEPTH.
REQ-019 Occupancy: count' = count + push - pop; simultaneous push and pop leaves count unchanged.
REQ-020 s_axis_tready is registered as (count' < DEPTH); it has no combinational path from m_axis_tready.
REQ-021 Full (count=DEPTH): s_axis_tready=0; a pop at edge N raises s_axis_tready after edge N.
REQ-022 Empty (count=0): m_axis_tvalid=0; m_axis payload holds its last value.
REQ-023 Once m_axis_tvalid=1, it and the payload remain stable until the pop edge.
REQ-024 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-025 Upstream changes to s_axis_* while s_axis_tready=0 are ignored.

Reset
REQ-026 Reset clears count and pointers to 0.
REQ-027 Reset drives m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0 and s_axis_tready=0.
REQ-028 When reset is deasserted, s_axis_tready=1 after the first edge on which axis_reset=0.
REQ-029 Reset mid-stream discards all stored beats with no partial beat emitted; tlast framing is not repaired.
REQ-030 Reset asserted together with push or pop wins; neither the push nor the pop takes effect.
REQ-031 level=0 and almost_full=0 in reset (when present).

Configuration
REQ-032 With macro AXIS_BUF_LEVEL_EN defined, level and almost_full ports and their logic are present; level equals count, registered.
REQ-033 Without AXIS_BUF_LEVEL_EN, those ports and their logic are absent; all other behaviour is identical.

Verification (DEPTH=4, AXIS_BUF_LEVEL_EN defined)
REQ-034 Single beat: push tdata=0xA5, tlast=1 at edge 1 -> m_axis_tvalid=1, tdata=0xA5, tlast=1 after edge 1; level=1.
REQ-035 Fill and backpressure: m_axis_tready=0, push 4 beats -> s_axis_tready=0 after 4th push, level=4, almost_full=1 from level 3; 5th beat held off.
REQ-036 Full with simultaneous event: at full, raise m_axis_tready for 1 cycle -> one pop, s_axis_tready=1 next cycle, level=3.
REQ-037 Streaming with wrap: 20 beats 0..19, both sides ready -> out 0..19 in order, one beat per cycle after first, level constant at 1.
REQ-038 Random tvalid/tready (10k beats) -> output matches scoreboard; m_axis stable while stalled; pointers wrap without loss.
REQ-039 Mid-stream reset with 3 stored beats -> after reset, m_axis_tvalid=0, level=0, s_axis_tready=1 one cycle after release; next beat out is the first beat pushed after release.
